mem_responder: RTL and testbench

//   Memory-side responder for the multicycle core's unified instruction/data port.

---
 rtl/mem_resp_pkg.sv | 27 ++
 rtl/mem_resp_lane_align.sv | 80 ++++++++
 rtl/mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for mem_responder: access-size codes, FSM encoding and
// the alignment rule used by the error decode.
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // Size code 3 is never legal, so it falls out as misaligned here.
  function automatic logic legal_align(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_resp_lane_align.sv
// Combinational byte-lane steering: load extract/extend and store merge
// for byte, half and word accesses within one 32-bit RAM word.
module mem_resp_lane_align
  import mem_resp_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;
  logic [31:0] lane_data_s;
  logic [3:0]  lane_mask_s;

  // Load path: pick the addressed byte/half, then sign- or zero-extend.
  always_comb begin
    byte_sel_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel_s = word[7:0];
      2'd1:    byte_sel_s = word[15:8];
      2'd2:    byte_sel_s = word[23:16];
      2'd3:    byte_sel_s = word[31:24];
      default: byte_sel_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_sel_s = word[31:16];
    end else begin
      half_sel_s = word[15:0];
    end
    load_data = 32'h0000_0000;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel_s[7]}}, byte_sel_s};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel_s[15]}}, half_sel_s};
      SZ_WORD: load_data = word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store path: replicate the right-justified data across lanes, enable only the addressed ones.
  always_comb begin
    lane_data_s = wdata;
    lane_mask_s = 4'b0000;
    case (size)
      SZ_BYTE: begin
        lane_data_s = {4{wdata[7:0]}};
        lane_mask_s = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        lane_data_s = {2{wdata[15:0]}};
        if (addr_lo[1]) begin
          lane_mask_s = 4'b1100;
        end else begin
          lane_mask_s = 4'b0011;
        end
      end
      SZ_WORD: begin
        lane_data_s = wdata;
        lane_mask_s = 4'b1111;
      end
      default: begin
        lane_data_s = wdata;
        lane_mask_s = 4'b0000;
      end
    endcase
    store_word = word;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask_s[i]) begin
        store_word[8*i +: 8] = lane_data_s[8*i +: 8];
      end else begin
        store_word[8*i +: 8] = word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states, one-cycle response.
// Optional tohost register enabled by defining MEM_RESP_TOHOST_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef MEM_RESP_TOHOST_EN
  ,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS * 4);

  state_t      state_r, state_next_s;
  logic [3:0]  wait_cnt_r;
  logic        we_r, unsigned_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r;
  logic        rsp_valid_r, rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic        ready_s, accept_s;
  logic        in_range_s, err_s, tohost_hit_s, ram_we_s;
  logic [31:0] old_word_s, load_data_s, store_word_s, tohost_rd_s, rdata_s;
  logic [AW-1:0] word_idx_s;

  logic [31:0] ram [DEPTH_WORDS];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  if (req_valid) state_next_s = S_WAIT; else state_next_s = S_IDLE;
      S_WAIT:  if (wait_cnt_r == 4'd0) state_next_s = S_RESP; else state_next_s = S_WAIT;
      S_RESP:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM outputs; ready is masked by rst so nothing is accepted during reset
  always_comb begin
    if ((state_r == S_IDLE) && !rst) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign req_ready = ready_s;
  assign accept_s  = req_valid && ready_s;

  // Request latches and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
      we_r       <= 1'b0;
      size_r     <= SZ_BYTE;
      unsigned_r <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
    end else if (accept_s) begin
      wait_cnt_r <= 4'(WAIT_CYCLES);
      we_r       <= req_we;
      size_r     <= req_size;
      unsigned_r <= req_unsigned;
      addr_r     <= req_addr;
      wdata_r    <= req_wdata;
    end else if ((state_r == S_WAIT) && (wait_cnt_r != 4'd0)) begin
      wait_cnt_r <= wait_cnt_r - 4'd1;
    end
  end

`ifdef MEM_RESP_TOHOST_EN
  assign tohost_hit_s = (addr_r == TOHOST_ADDR);
`else
  assign tohost_hit_s = 1'b0;
`endif

  assign word_idx_s = addr_r[AW+1:2];
  assign old_word_s = ram[word_idx_s];
  assign in_range_s = ({1'b0, addr_r} < BYTE_LIMIT);

  mem_resp_lane_align u_align (
    .word        (old_word_s),
    .addr_lo     (addr_r[1:0]),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .store_word  (store_word_s)
  );

  // Error decode and load-result mux; the tohost word bypasses the range check
  always_comb begin
    if (tohost_hit_s) begin
      err_s = (size_r != SZ_WORD);
    end else begin
      err_s = !(legal_align(size_r, addr_r[1:0]) && in_range_s);
    end
    if (err_s || we_r) begin
      rdata_s = 32'h0000_0000;
    end else if (tohost_hit_s) begin
      rdata_s = tohost_rd_s;
    end else begin
      rdata_s = load_data_s;
    end
    ram_we_s = (state_r == S_RESP) && we_r && !err_s && !tohost_hit_s && !rst;
  end

  // Response registers, loaded on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if ((state_r == S_WAIT) && (wait_cnt_r == 4'd0)) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= rdata_s;
      rsp_err_r   <= err_s;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // RAM write commits on the edge leaving RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram[word_idx_s] <= store_word_s;
    end
  end

`ifdef MEM_RESP_TOHOST_EN
  logic        tohost_valid_r;
  logic [31:0] tohost_data_r;

  // Sticky tohost register, written by a legal word store to TOHOST_ADDR
  always_ff @(posedge clk) begin
    if (rst) begin
      tohost_valid_r <= 1'b0;
      tohost_data_r  <= 32'h0000_0000;
    end else if ((state_r == S_RESP) && we_r && tohost_hit_s && !err_s) begin
      tohost_valid_r <= 1'b1;
      tohost_data_r  <= wdata_r;
    end
  end

  assign tohost_rd_s  = tohost_data_r;
  assign tohost_valid = tohost_valid_r;
  assign tohost_data  = tohost_data_r;
`else
  assign tohost_rd_s = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic against a byte-level reference model. Honours MEM_RESP_TOHOST_EN.
module tb_mem_responder;

  localparam int unsigned WAITC = 1;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef MEM_RESP_TOHOST_EN
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        mdl_tohost_valid = 1'b0;
  logic [31:0] mdl_tohost_data = 32'h0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mdl_mem [DEPTH];

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC),
    .INIT_FILE   (""),
    .TOHOST_ADDR (32'h0000_1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
`ifdef MEM_RESP_TOHOST_EN
    ,
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: byte-granular view of memory, applied in request order.
  function automatic void mdl_access(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rdata);
    int nb;
    int off;
    logic hit;
    logic [31:0] w;
    hit = 1'b0;
`ifdef MEM_RESP_TOHOST_EN
    hit = (addr == 32'h0000_1000);
`endif
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    rdata = 32'h0;
    if (hit) err = (nb != 4);
    else err = (nb == 0) || ((addr % 32'(nb)) != 32'd0) || (addr >= 32'(DEPTH * 4));
    if (err) return;
`ifdef MEM_RESP_TOHOST_EN
    if (hit) begin
      if (we) begin
        mdl_tohost_valid = 1'b1;
        mdl_tohost_data  = wdata;
      end else begin
        rdata = mdl_tohost_data;
      end
      return;
    end
`endif
    w = mdl_mem[addr[11:2]];
    off = int'(addr % 32'd4);
    if (we) begin
      for (int i = 0; i < nb; i++) w[(off + i) * 8 +: 8] = wdata[i * 8 +: 8];
      mdl_mem[addr[11:2]] = w;
    end else begin
      rdata = w >> (off * 8);
      if (nb == 1) begin
        rdata = rdata & 32'h0000_00FF;
        if (!uns && rdata[7]) rdata = rdata | 32'hFFFF_FF00;
      end else if (nb == 2) begin
        rdata = rdata & 32'h0000_FFFF;
        if (!uns && rdata[15]) rdata = rdata | 32'hFFFF_0000;
      end
    end
  endfunction

  // One full transaction, entered and left at a falling edge.
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] got_rdata, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          n;
    int          lat;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    got_rdata = 32'h0;
    got_err = 1'b0;
    if (!req_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    mdl_access(we, size, uns, addr, wdata, exp_err, exp_rdata);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("ready_busy", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", 32'(lat), 32'(WAITC + 1));
    got_rdata = rsp_rdata;
    got_err = rsp_err;
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    @(negedge clk);
    check_eq("pulse_width", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] r;
  logic        e;
  logic [31:0] exp_q [$];
  logic [31:0] b_addr [3];
  logic [1:0]  b_size [3];
  int          acc, rsp;
  logic        x_err;
  logic [31:0] x_rdata;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
`ifdef MEM_RESP_TOHOST_EN
    check_eq("rst_tohost_valid", 32'(tohost_valid), 32'd0);
    check_eq("rst_tohost_data", tohost_data, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int w = 0; w < 64; w++) xact(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom(), r, e);
    xact(1'b1, 2'd2, 1'b0, 32'h0000_0FFC, $urandom(), r, e);

    // Word store/load
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r, e);
    check_eq("t1_st_err", 32'(e), 32'd0);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, e);
    check_eq("t1_ld_data", r, 32'hDEADBEEF);
    check_eq("t1_ld_err", 32'(e), 32'd0);

    // Byte store and signed/unsigned loads
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, r, e);
    xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h80, r, e);
    xact(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, r, e);
    check_eq("t2_lb", r, 32'hFFFFFF80);
    xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, r, e);
    check_eq("t2_lbu", r, 32'h00000080);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, e);
    check_eq("t2_lw", r, 32'h00008000);

    // Error cases and range boundary
    xact(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, r, e);
    check_eq("t3_half_mis_err", 32'(e), 32'd1);
    check_eq("t3_half_mis_data", r, 32'd0);
    xact(1'b1, 2'd2, 1'b0, 32'h1002, 32'h55555555, r, e);
    check_eq("t3_oor_st_err", 32'(e), 32'd1);
    xact(1'b0, 2'd2, 1'b0, 32'h0FFC, 32'h0, r, e);
    check_eq("t3_last_word_err", 32'(e), 32'd0);
    xact(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, r, e);
    check_eq("t3_size3_err", 32'(e), 32'd1);
    xact(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, r, e);
`ifdef MEM_RESP_TOHOST_EN
    check_eq("t3_tohost_ld_err", 32'(e), 32'd0);
    check_eq("t3_tohost_ld_data", r, 32'd0);
    // tohost store
    xact(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1, r, e);
    check_eq("t6_err", 32'(e), 32'd0);
    check_eq("t6_valid", 32'(tohost_valid), 32'd1);
    check_eq("t6_data", tohost_data, 32'd1);
    xact(1'b1, 2'd0, 1'b0, 32'h1000, 32'h7, r, e);
    check_eq("t6_byte_err", 32'(e), 32'd1);
    check_eq("t6_sticky", 32'(tohost_valid), 32'd1);
`else
    check_eq("t3_1000_err", 32'(e), 32'd1);
`endif

    // Back-to-back requests with req_valid held high
    b_addr[0] = 32'h10; b_size[0] = 2'd2;
    b_addr[1] = 32'h14; b_size[1] = 2'd2;
    b_addr[2] = 32'h11; b_size[2] = 2'd0;
    acc = 0; rsp = 0;
    req_we = 1'b0; req_unsigned = 1'b0; req_wdata = 32'h0;
    req_addr = b_addr[0]; req_size = b_size[0]; req_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && rsp < 3; cyc++) begin
      if (acc > rsp) check_eq("b2b_ready_low", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) check_eq("b2b_extra_rsp", 32'd1, 32'd0);
        else check_eq("b2b_rdata", rsp_rdata, exp_q.pop_front());
        rsp++;
      end
      if (req_ready && req_valid) begin
        mdl_access(1'b0, b_size[acc], 1'b0, b_addr[acc], 32'h0, x_err, x_rdata);
        exp_q.push_back(x_rdata);
        acc++;
        @(posedge clk);
        #1;
        if (acc < 3) begin
          req_addr = b_addr[acc];
          req_size = b_size[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check_eq("b2b_accepts", 32'(acc), 32'd3);
    check_eq("b2b_responses", 32'(rsp), 32'd3);
    repeat (2) begin
      check_eq("b2b_no_extra", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end

    // Reset during WAIT aborts a store
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("t5_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("t5_ready_low", 32'(req_ready), 32'd0);
    end
    rst = 1'b0;
`ifdef MEM_RESP_TOHOST_EN
    mdl_tohost_valid = 1'b0;
    mdl_tohost_data = 32'h0;
    check_eq("t6_cleared", 32'(tohost_valid), 32'd0);
`endif
    repeat (2) begin
      @(negedge clk);
      check_eq("t5_no_late_rsp", 32'(rsp_valid), 32'd0);
    end
    xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, e);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 8) a = 32'($urandom_range(0, 255));
      else if (sel == 8) a = 32'h0FFC + 32'($urandom_range(0, 15));
      else a = $urandom() | 32'h0001_0000;
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom(), r, e);
    end
`ifdef MEM_RESP_TOHOST_EN
    check_eq("rand_tohost_valid", 32'(tohost_valid), 32'(mdl_tohost_valid));
    check_eq("rand_tohost_data", tohost_data, mdl_tohost_data);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
